mag_cmp_seq: RTL and testbench

Parametrised, slice-serial magnitude comparator. It compares two WIDTH-bit operands SLICE bits per clock, MSB slice first, and reports equal, less-than and greater-than through a start/ready/done handshake. Supports unsigned and two's-complement operands. It is the sequential, multi-bit successor to the 1-bit equality comparator in the comparator core set, and is intended for wide operands where a single-cycle compare would limit timing.

---
 rtl/mag_cmp_seq.sv | 146 ++++++++++++++
 tb/tb_mag_cmp_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mag_cmp_seq.sv
// Slice-serial magnitude comparator: MSB slice first, SLICE bits per clock, unsigned or two's-complement.
// Build option: define CMP_EARLY_EXIT_EN to finish on the first differing slice (data-dependent latency).

module mag_cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             lt,
  output logic             gt
);
  assign lt = (a < b);
  assign gt = (a > b);
endmodule

module mag_cmp_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             ready,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);
  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("mag_cmp_seq: WIDTH must be >= 2 and a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     s_lt, s_gt;
  logic             cur_lt, cur_gt;
  logic [WIDTH-1:0] msb_flip;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  for (genvar g = 0; g < N; g++) begin : g_slice
    mag_cmp_slice #(.SLICE(SLICE)) u_slice (
      .a (a_r[g*SLICE +: SLICE]),
      .b (b_r[g*SLICE +: SLICE]),
      .lt(s_lt[g]),
      .gt(s_gt[g])
    );
  end

  assign cur_lt = s_lt[idx];
  assign cur_gt = s_gt[idx];

`ifndef CMP_EARLY_EXIT_EN
  // First MSB-side difference, held while the remaining slices are walked.
  logic hit_lt, hit_gt, decided;
  assign decided = hit_lt | hit_gt;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      gt     <= 1'b0;
      idx    <= IDX_W'(N-1);
      a_r    <= '0;
      b_r    <= '0;
`ifndef CMP_EARLY_EXIT_EN
      hit_lt <= 1'b0;
      hit_gt <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r    <= a ^ msb_flip;
            b_r    <= b ^ msb_flip;
            idx    <= IDX_W'(N-1);
            eq     <= 1'b0;
            lt     <= 1'b0;
            gt     <= 1'b0;
            ready  <= 1'b0;
            state  <= CMP;
`ifndef CMP_EARLY_EXIT_EN
            hit_lt <= 1'b0;
            hit_gt <= 1'b0;
`endif
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        CMP: begin
`ifdef CMP_EARLY_EXIT_EN
          if (cur_lt || cur_gt) begin
            lt    <= cur_lt;
            gt    <= cur_gt;
            done  <= 1'b1;
            ready <= 1'b1;
            state <= DONE;
          end else if (idx == '0) begin
            eq    <= 1'b1;
            done  <= 1'b1;
            ready <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`else
          if (idx == '0) begin
            lt    <= decided ? hit_lt : cur_lt;
            gt    <= decided ? hit_gt : cur_gt;
            eq    <= !decided && !cur_lt && !cur_gt;
            done  <= 1'b1;
            ready <= 1'b1;
            state <= DONE;
          end else begin
            if (!decided) begin
              hit_lt <= cur_lt;
              hit_gt <= cur_gt;
            end
            idx <= idx - 1'b1;
          end
`endif
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mag_cmp_seq.sv
// Bench for mag_cmp_seq (WIDTH=16, SLICE=4): directed table, handshake/reset sequences, random sweep vs model.
module tb_mag_cmp_seq;
  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready, done, eq, lt, gt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mag_cmp_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .ready(ready), .done(done),
    .eq(eq), .lt(lt), .gt(gt)
  );

  // res packs {eq, lt, gt}
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    logic [2:0]   res;
    int           lat_full;
    int           lat_early;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_res(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm);
    int sa, sb;
    if (sm) begin
      sa = int'($signed(av));
      sb = int'($signed(bv));
    end else begin
      sa = int'(av);
      sb = int'(bv);
    end
    if (sa == sb) return 3'b100;
    if (sa < sb)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = 1; i <= N; i++)
      if (((av >> (S*(N-i))) & 16'hF) != ((bv >> (S*(N-i))) & 16'hF)) return i;
`endif
    return N;
  endfunction

  function automatic int pick_lat(input int full, input int early);
`ifdef CMP_EARLY_EXIT_EN
    return early;
`else
    return full;
`endif
  endfunction

  // One compare: start driven at negedge, accepted at the next posedge (edge 0).
  // With junk=1, start stays high with changing operands while busy.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm,
                        input logic [2:0] exp_res, input int exp_lat, input bit junk, input string tag);
    int lat;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; signed_mode = sm;
    @(posedge clk); #1;
    chk({tag, "_clr"}, {eq, lt, gt}, 3'b000);
    chk({tag, "_busy"}, ready, 1'b0);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      start = junk;
      if (junk) begin
        a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, {eq, lt, gt}, exp_res);
    chk({tag, "_rdy"}, ready, 1'b1);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{16'h1234, 16'h1234, 1'b0, 3'b100, 4, 4};
    tbl[1] = '{16'h8000, 16'h7FFF, 1'b0, 3'b001, 4, 1};
    tbl[2] = '{16'h8000, 16'h7FFF, 1'b1, 3'b010, 4, 1};
    tbl[3] = '{16'h1235, 16'h1234, 1'b0, 3'b001, 4, 4};
    tbl[4] = '{16'h1234, 16'h1235, 1'b0, 3'b010, 4, 4};
    tbl[5] = '{16'h0001, 16'h0002, 1'b0, 3'b010, 4, 4};
    tbl[6] = '{16'hFFFF, 16'h0000, 1'b1, 3'b010, 4, 1};
    tbl[7] = '{16'h0000, 16'h0000, 1'b1, 3'b100, 4, 4};
    tbl[8] = '{16'h1334, 16'h1234, 1'b0, 3'b001, 4, 2};
    tbl[9] = '{16'h1244, 16'h1234, 1'b0, 3'b001, 4, 3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_res", {eq, lt, gt}, 3'b000);
    @(negedge clk); reset_n = 1'b1;

    // Directed table, with one idle cycle between entries
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].res,
             pick_lat(tbl[i].lat_full, tbl[i].lat_early), 1'b0, $sformatf("tbl%0d", i));
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_hold", i), {done, eq, lt, gt}, {1'b0, tbl[i].res});
    end

    // start held with junk operands while busy, then back-to-back start in the done cycle
    run_op(16'h1235, 16'h1234, 1'b0, 3'b001, 4, 1'b1, "junk");
    run_op(16'h0001, 16'h0002, 1'b0, 3'b010, 4, 1'b0, "b2b");
    @(negedge clk); start = 1'b0;

    // Reset asserted at edge 2 of a compare that cannot finish before edge 4
    @(negedge clk); start = 1'b1; a = 16'h1234; b = 16'h1235; signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_ready", ready, 1'b1);
    chk("mrst_done", done, 1'b0);
    chk("mrst_res", {eq, lt, gt}, 3'b000);
    @(negedge clk); reset_n = 1'b1;
    begin
      logic seen = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        seen |= done;
      end
      chk("mrst_nodone", seen, 1'b0);
    end
    run_op(16'hABCD, 16'hABCD, 1'b0, 3'b100, 4, 1'b0, "post_rst");

    // Random sweep against the reference model, with random idle gaps
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? (ra ^ W'(1 << $urandom_range(0, W-1))) : W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      rs = 1'($urandom);
      run_op(ra, rb, rs, ref_res(ra, rb, rs), ref_lat(ra, rb), 1'($urandom_range(0, 3) == 0), "rnd");
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); start = 1'b0;
        @(posedge clk);
      end
    end
    @(negedge clk); start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
